// File: rtl/fetch_unit_pkg.sv
// Shared fetch constants and record types for fetch_unit and its prefetch FIFO.
// The optional FETCH_ALIGN_CHECK_EN feature uses FAULT_MISALIGNED as its fault value.
package fetch_unit_pkg;
  localparam int INSN_BYTES = 4;
  localparam int MEM_ADDR_W = 14;
  localparam int PC_W       = 64;
  localparam int INSN_W     = 32;

  // Value driven on o_fault when a redirect target is not word aligned.
  localparam logic FAULT_MISALIGNED = 1'b1;

  // One buffered instruction together with the byte PC it was fetched from.
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INSN_W-1:0] insn;
  } fetch_entry_t;

  // One stage of the BRAM read pipeline: a read is in flight for pc when valid.
  typedef struct packed {
    logic            valid;
    logic [PC_W-1:0] pc;
  } stage_t;
endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: DEPTH entries of {pc, insn}, with push, pop and a synchronous clear.
// The head output is held at its last shown value while the FIFO is empty.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [AW:0]  count,
  output logic         full,
  output logic         empty
);
  fetch_entry_t mem [DEPTH];
  fetch_entry_t last_q;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic do_push;
  logic do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? last_q : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; clear wins over push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Storage array; contents are only observed through head when non-empty.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= push_data;
  end

  // Remember the displayed head so the outputs stay stable across empty periods.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= '0;
    else        last_q <= head;
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, streams BRAM reads through a
// two-stage in-flight pipeline into a prefetch FIFO, and flushes on redirect.
// Optional macro FETCH_ALIGN_CHECK_EN adds o_fault for misaligned redirects.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = 64'h0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  output logic                  o_mem_read,
  output logic [MEM_ADDR_W-1:0] o_mem_address,
  input  logic [INSN_W-1:0]     i_mem_value,
  input  logic                  i_redirect,
  input  logic [PC_W-1:0]       i_redirect_pc,
  output logic                  o_insn_valid,
  output logic [INSN_W-1:0]     o_insn,
  output logic [PC_W-1:0]       o_insn_pc,
  input  logic                  i_insn_ready
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic                  o_fault
`endif
);
  localparam int AW = $clog2(DEPTH);

  // Downstream handshake: a transfer happens on an edge where o_insn_valid and
  // i_insn_ready are both high; o_insn_valid never depends on i_insn_ready.

  logic [PC_W-1:0] fetch_pc;
  stage_t          s1;
  stage_t          s2;
  fetch_entry_t    head;
  logic [AW:0]     count;
  logic            full;
  logic            empty;
  logic [AW+1:0]   credit;
  logic            halted;
  logic            issue;

`ifdef FETCH_ALIGN_CHECK_EN
  assign halted = o_fault;
`else
  assign halted = 1'b0;
`endif

  // Buffered words plus reads still in flight must fit in the FIFO.
  assign credit = {1'b0, count} + (AW+2)'(s1.valid) + (AW+2)'(s2.valid);
  assign issue  = !i_redirect && !halted && !full && (credit < (AW+2)'(DEPTH));

  // Fetch PC, BRAM request registers and the in-flight pipeline.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fetch_pc      <= RESET_PC;
      o_mem_read    <= 1'b0;
      o_mem_address <= '0;
      s1            <= '0;
      s2            <= '0;
    end else if (i_redirect) begin
      fetch_pc   <= i_redirect_pc;
      o_mem_read <= 1'b0;
      s1         <= '0;
      s2         <= '0;
    end else begin
      s2 <= s1;
      if (issue) begin
        o_mem_address <= fetch_pc[MEM_ADDR_W+1:2];
        o_mem_read    <= 1'b1;
        s1            <= '{valid: 1'b1, pc: fetch_pc};
        fetch_pc      <= fetch_pc + PC_W'(INSN_BYTES);
      end else begin
        o_mem_read <= 1'b0;
        s1.valid   <= 1'b0;
      end
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  // Sticky misalignment fault; only reset or an aligned redirect clears it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)        o_fault <= 1'b0;
    else if (i_redirect) o_fault <= (i_redirect_pc[1:0] != 2'b00) ? FAULT_MISALIGNED : 1'b0;
  end
`endif

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .clear     (i_redirect),
    .push      (s2.valid && !i_redirect),
    .push_data ('{pc: s2.pc, insn: i_mem_value}),
    .pop       (i_insn_ready),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  assign o_insn_valid = !empty;
  assign o_insn       = head.insn;
  assign o_insn_pc    = head.pc;
endmodule
